// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the data-memory arbiter slice.
//   ADDR_WIDTH / DATA_WIDTH : geometry of the 512x32 data memory
//   state_t                 : arbiter sequencer states
//   REQ_CPU / REQ_DMA       : requester ids (bit index into the request vectors)
// ---------------------------------------------------------------------------
package dmem_pkg;

   localparam int ADDR_WIDTH = 9;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant. Holds no state: the priority
// pointer lives in the parent so it can be updated on the accept edge.
//   reqValid [1:0] : request valid per requester
//   prio           : requester favoured when both are valid
//   enable         : grants only issued while enabled (parent is IDLE)
//   grant    [1:0] : one-hot grant, zero when nothing is granted
//   grantId        : index of the granted requester (meaningful when grant != 0)
// ---------------------------------------------------------------------------
module rr_arbiter2
   import dmem_pkg::*;
(
   input  logic [1:0] reqValid,
   input  logic       prio,
   input  logic       enable,
   output logic [1:0] grant,
   output logic       grantId
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      grant   = 2'b00;
      grantId = REQ_CPU;
      if (enable) begin
         unique case (reqValid)
            2'b01: begin
               grant   = 2'b01;
               grantId = REQ_CPU;
            end
            2'b10: begin
               grant   = 2'b10;
               grantId = REQ_DMA;
            end
            2'b11: begin
               grantId = prio;
               grant   = (prio == REQ_DMA) ? 2'b10 : 2'b01;
            end
            default: begin
               grant   = 2'b00;
               grantId = REQ_CPU;
            end
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-ported, level-sensitive 512x32 data memory between the CPU
// load/store stage (requester 0) and the DMA/debug port (requester 1).
// One access at a time: IDLE (arbitrate/accept) -> ACCESS (memory driven for
// exactly one cycle) -> RESP (one-cycle response pulse).
//   clk, resetN      : clock, asynchronous active-low reset
//   reqValid/Ready   : per-requester valid/ready handshake (2 bits each)
//   reqWrite         : per-requester write flag
//   reqAddress       : packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   reqWriteData     : packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   respValid        : one-cycle completion pulse per requester
//   respReadData     : read result while respValid != 0 (0 for writes)
//   mem*             : memory-side address, data, write strobe and read data
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = dmem_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = dmem_pkg::DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic [1:0]              reqValid,
   output logic [1:0]              reqReady,
   input  logic [1:0]              reqWrite,
   input  logic [2*ADDR_WIDTH-1:0] reqAddress,
   input  logic [2*DATA_WIDTH-1:0] reqWriteData,
   output logic [1:0]              respValid,
   output logic [DATA_WIDTH-1:0]   respReadData,
   output logic [ADDR_WIDTH-1:0]   memReadAddress,
   output logic [ADDR_WIDTH-1:0]   memWriteAddress,
   output logic [DATA_WIDTH-1:0]   memWriteData,
   output logic                    memReadWrite,
   input  logic [DATA_WIDTH-1:0]   memReadData
);

   state_t state;
   state_t nextState;

   logic       prio;
   logic       idReg;
   logic       writeReg;
   logic [1:0] grant;
   logic       grantId;
   logic       accept;

   logic [ADDR_WIDTH-1:0] selAddress;
   logic [DATA_WIDTH-1:0] selWriteData;
   logic                  selWrite;

   rr_arbiter2 u_rr (
      .reqValid (reqValid),
      .prio     (prio),
      .enable   (state == IDLE),
      .grant    (grant),
      .grantId  (grantId)
   );

   // Grant is only non-zero for a valid requester, so a grant is an accept.
   assign reqReady = grant;
   assign accept   = |grant;

   // Request fields of the granted requester.
   always_comb begin
      selAddress   = reqAddress[ADDR_WIDTH-1:0];
      selWriteData = reqWriteData[DATA_WIDTH-1:0];
      selWrite     = reqWrite[0];
      if (grantId == REQ_DMA) begin
         selAddress   = reqAddress[2*ADDR_WIDTH-1:ADDR_WIDTH];
         selWriteData = reqWriteData[2*DATA_WIDTH-1:DATA_WIDTH];
         selWrite     = reqWrite[1];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!resetN) state <= IDLE;
      else         state <= nextState;
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (accept) nextState = ACCESS;
         ACCESS:  nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Request latch, memory drive and response registers.
   always_ff @(posedge clk or negedge resetN) begin
      // NOTE: every register here is reset, including address and data,
      // because they drive the memory pins directly and must not float to X
      // while the memory is reading combinationally.
      if (!resetN) begin
         prio            <= REQ_CPU;
         idReg           <= REQ_CPU;
         writeReg        <= 1'b0;
         memReadAddress  <= '0;
         memWriteAddress <= '0;
         memWriteData    <= '0;
         memReadWrite    <= 1'b0;
         respValid       <= 2'b00;
         respReadData    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  idReg           <= grantId;
                  writeReg        <= selWrite;
                  memReadAddress  <= selAddress;
                  memWriteAddress <= selAddress;
                  memWriteData    <= selWriteData;
                  memReadWrite    <= selWrite;
                  prio            <= ~grantId;
               end
            end
            ACCESS: begin
               // Write strobe lasts exactly the ACCESS cycle; address and
               // data keep their values so the memory read port is stable.
               memReadWrite <= 1'b0;
               respReadData <= writeReg ? '0 : memReadData;
               respValid    <= (idReg == REQ_DMA) ? 2'b10 : 2'b01;
            end
            RESP: begin
               respValid <= 2'b00;
            end
            default: begin
               memReadWrite <= 1'b0;
               respValid    <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 512x32 memory. Unwritten
// words read back a preload pattern (0xA5000000 | address, word 5 = DEADBEEF).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic                    clk;
   logic                    resetN;
   logic [1:0]              reqValid;
   logic [1:0]              reqReady;
   logic [1:0]              reqWrite;
   logic [2*ADDR_WIDTH-1:0] reqAddress;
   logic [2*DATA_WIDTH-1:0] reqWriteData;
   logic [1:0]              respValid;
   logic [DATA_WIDTH-1:0]   respReadData;
   logic [ADDR_WIDTH-1:0]   memReadAddress;
   logic [ADDR_WIDTH-1:0]   memWriteAddress;
   logic [DATA_WIDTH-1:0]   memWriteData;
   logic                    memReadWrite;
   logic [DATA_WIDTH-1:0]   memReadData;

   int checks = 0;
   int errors = 0;

   dmem_arbiter dut (
      .clk             (clk),
      .resetN          (resetN),
      .reqValid        (reqValid),
      .reqReady        (reqReady),
      .reqWrite        (reqWrite),
      .reqAddress      (reqAddress),
      .reqWriteData    (reqWriteData),
      .respValid       (respValid),
      .respReadData    (respReadData),
      .memReadAddress  (memReadAddress),
      .memWriteAddress (memWriteAddress),
      .memWriteData    (memWriteData),
      .memReadWrite    (memReadWrite),
      .memReadData     (memReadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: write on clock edges while readWrite is high,
   // combinational read.
   logic [31:0] mem     [512];
   bit          written [512];

   function automatic logic [31:0] initVal(input logic [8:0] a);
      if (a == 9'h005) return 32'hDEADBEEF;
      return 32'hA5000000 | {23'd0, a};
   endfunction

   always @(posedge clk) begin
      if (memReadWrite) begin
         mem[memWriteAddress]     = memWriteData;
         written[memWriteAddress] = 1'b1;
      end
   end

   assign memReadData = written[memReadAddress] ? mem[memReadAddress]
                                                : initVal(memReadAddress);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic setReq(input int id, input logic wr, input logic [8:0] addr,
                         input logic [31:0] data);
      reqValid = 2'b00;
      reqValid[id] = 1'b1;
      reqWrite[id] = wr;
      reqAddress[id*ADDR_WIDTH +: ADDR_WIDTH] = addr;
      reqWriteData[id*DATA_WIDTH +: DATA_WIDTH] = data;
   endtask

   // One complete access starting at the next negedge (cycle 0 = accept).
   task automatic doAccess(input string tag, input int id, input logic wr,
                           input logic [8:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expRd);
      logic [1:0] oneHot;
      oneHot = (id == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      setReq(id, wr, addr, wdata);
      #1;
      checks++;
      if (reqReady !== oneHot) begin
         errors++;
         $display("FAIL %s ready: got %b want %b", tag, reqReady, oneHot);
      end
      @(posedge clk);
      @(negedge clk);
      reqValid = 2'b00;
      checks++;
      if (memReadWrite !== wr || memReadAddress !== addr || memWriteAddress !== addr) begin
         errors++;
         $display("FAIL %s access: got rw=%b ra=%h wa=%h want rw=%b a=%h",
                  tag, memReadWrite, memReadAddress, memWriteAddress, wr, addr);
      end
      if (wr) begin
         checks++;
         if (memWriteData !== wdata) begin
            errors++;
            $display("FAIL %s wdata: got %h want %h", tag, memWriteData, wdata);
         end
      end
      checks++;
      if (respValid !== 2'b00 || reqReady !== 2'b00) begin
         errors++;
         $display("FAIL %s access-quiet: got resp=%b ready=%b want 00/00",
                  tag, respValid, reqReady);
      end
      @(negedge clk);
      checks++;
      if (respValid !== oneHot || respReadData !== expRd || memReadWrite !== 1'b0) begin
         errors++;
         $display("FAIL %s resp: got v=%b d=%h rw=%b want v=%b d=%h rw=0",
                  tag, respValid, respReadData, memReadWrite, oneHot, expRd);
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      resetN = 1'b0;
      reqValid = 2'b00;
      @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic test_reset();
      resetN       = 1'b0;
      reqValid     = 2'b00;
      reqWrite     = 2'b00;
      reqAddress   = '0;
      reqWriteData = '0;
      #1;
      checks++;
      if (reqReady !== 2'b00 || respValid !== 2'b00 || respReadData !== 32'd0) begin
         errors++;
         $display("FAIL reset outputs: got ready=%b resp=%b d=%h want 0",
                  reqReady, respValid, respReadData);
      end
      checks++;
      if (memReadWrite !== 1'b0 || memReadAddress !== 9'd0 ||
          memWriteAddress !== 9'd0 || memWriteData !== 32'd0) begin
         errors++;
         $display("FAIL reset mem: got rw=%b ra=%h wa=%h wd=%h want 0",
                  memReadWrite, memReadAddress, memWriteAddress, memWriteData);
      end
      repeat (2) @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic test_single_read();
      doAccess("single_read", 0, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF);
   endtask

   task automatic test_write_then_read();
      int rwHigh;
      doAccess("wr_1ff", 1, 1'b1, 9'h1FF, 32'h12345678, 32'h0);
      rwHigh = 0;
      // Count write-strobe cycles over a fresh write, sampled mid-cycle.
      fork
         begin
            for (int c = 0; c < 6; c++) begin
               @(negedge clk);
               #2;
               if (memReadWrite === 1'b1) rwHigh++;
            end
         end
         doAccess("wr_1ff_again", 1, 1'b1, 9'h1FF, 32'h12345678, 32'h0);
      join
      checks++;
      if (rwHigh !== 1) begin
         errors++;
         $display("FAIL write_strobe_cycles: got %0d want 1", rwHigh);
      end
      doAccess("rd_1ff", 0, 1'b0, 9'h1FF, 32'h0, 32'h12345678);
   endtask

   task automatic test_contention();
      int gCycle [8];
      int gId    [8];
      int nGrant;
      applyReset();
      nGrant = 0;
      @(negedge clk);
      setReq(0, 1'b0, 9'h005, 32'h0);
      setReq(1, 1'b0, 9'h0C8, 32'h0);
      reqValid = 2'b11;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         checks++;
         if (reqReady === 2'b11) begin
            errors++;
            $display("FAIL contention_onehot cycle %0d: got %b want at most one bit", c, reqReady);
         end
         if (reqReady !== 2'b00 && nGrant < 8) begin
            gCycle[nGrant] = c;
            gId[nGrant]    = (reqReady == 2'b10) ? 1 : 0;
            nGrant++;
         end
      end
      @(negedge clk);
      reqValid = 2'b00;
      checks++;
      if (nGrant !== 4) begin
         errors++;
         $display("FAIL contention_count: got %0d want 4", nGrant);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (gId[i] !== (i % 2) || gCycle[i] !== 3 * i) begin
               errors++;
               $display("FAIL contention_grant %0d: got id=%0d cycle=%0d want id=%0d cycle=%0d",
                        i, gId[i], gCycle[i], i % 2, 3 * i);
            end
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_withdrawal();
      int badResp;
      @(negedge clk);
      setReq(0, 1'b0, 9'h005, 32'h0);
      #1;
      checks++;
      if (reqReady !== 2'b01) begin
         errors++;
         $display("FAIL withdraw_ready0: got %b want 01", reqReady);
      end
      @(negedge clk);
      setReq(1, 1'b0, 9'h0C8, 32'h0);
      #1;
      checks++;
      if (reqReady !== 2'b00) begin
         errors++;
         $display("FAIL withdraw_ready_access: got %b want 00", reqReady);
      end
      @(negedge clk);
      reqValid = 2'b00;
      checks++;
      if (respValid !== 2'b01 || respReadData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL withdraw_resp0: got v=%b d=%h want 01 DEADBEEF", respValid, respReadData);
      end
      badResp = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (respValid !== 2'b00 || reqReady !== 2'b00) badResp++;
      end
      checks++;
      if (badResp !== 0) begin
         errors++;
         $display("FAIL withdraw_no_grant: got %0d active cycles want 0", badResp);
      end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      setReq(1, 1'b1, 9'h064, 32'h55AA55AA);
      @(negedge clk);
      reqValid = 2'b00;
      checks++;
      if (memReadWrite !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: got rw=%b want 1", memReadWrite);
      end
      resetN = 1'b0;
      #1;
      checks++;
      if (memReadWrite !== 1'b0 || respValid !== 2'b00 || reqReady !== 2'b00) begin
         errors++;
         $display("FAIL midreset_drop: got rw=%b resp=%b ready=%b want 0/00/00",
                  memReadWrite, respValid, reqReady);
      end
      @(negedge clk);
      checks++;
      if (respValid !== 2'b00) begin
         errors++;
         $display("FAIL midreset_noresp: got %b want 00", respValid);
      end
      resetN = 1'b1;
      doAccess("midreset_read", 0, 1'b0, 9'h0C8, 32'h0, 32'hA50000C8);
   endtask

   task automatic test_full_range();
      doAccess("fr_rd0_init", 0, 1'b0, 9'h000, 32'h0, 32'hA5000000);
      doAccess("fr_wr0_r0",   0, 1'b1, 9'h000, 32'h11110000, 32'h0);
      doAccess("fr_wr511_r1", 1, 1'b1, 9'h1FF, 32'h222201FF, 32'h0);
      doAccess("fr_rd0_r1",   1, 1'b0, 9'h000, 32'h0, 32'h11110000);
      doAccess("fr_rd511_r0", 0, 1'b0, 9'h1FF, 32'h0, 32'h222201FF);
      doAccess("fr_wr511_r0", 0, 1'b1, 9'h1FF, 32'h333301FF, 32'h0);
      doAccess("fr_wr0_r1",   1, 1'b1, 9'h000, 32'h44440000, 32'h0);
      doAccess("fr_rd0_r0",   0, 1'b0, 9'h000, 32'h0, 32'h44440000);
      doAccess("fr_rd511_r1", 1, 1'b0, 9'h1FF, 32'h0, 32'h333301FF);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_then_read();
      test_contention();
      test_withdrawal();
      test_reset_mid_write();
      test_full_range();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
